// File: rtl/array_accu_pkg.sv
// Shared types and default widths for the array accumulator feed path.
package array_accu_pkg;

  localparam int DEF_CACHE_WIDTH = 512;
  localparam int DEF_DATA_WIDTH  = 32;
  localparam int LANES           = DEF_CACHE_WIDTH / DEF_DATA_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    WAIT_RES,
    WRITE,
    FIN
  } state_t;

endpackage

// File: rtl/line_fifo.sv
// Synchronous line buffer; pointers carry one extra wrap bit so full and empty
// can be told apart without a separate occupancy counter.
module line_fifo
  import array_accu_pkg::*;
#(
  parameter int WIDTH = DEF_CACHE_WIDTH,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  // Storage is left unreset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/array_accu_feed.sv
// Feeds buffered read lines to the pipelined array accumulator one batch at a
// time and forwards each batch result as a write request.
module array_accu_feed
  import array_accu_pkg::*;
#(
  parameter int CACHE_WIDTH = DEF_CACHE_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH  = 8,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [CNT_WIDTH-1:0]   batch_len,
  input  logic [CNT_WIDTH-1:0]   num_batches,
  input  logic                   rd_valid,
  input  logic [CACHE_WIDTH-1:0] rd_data,
  output logic                   rd_ready,
  output logic                   acc_inc,
  output logic                   acc_out,
  output logic [CACHE_WIDTH-1:0] acc_array,
  input  logic                   acc_ready,
  input  logic [CACHE_WIDTH-1:0] acc_res,
  output logic                   wr_valid,
  output logic [CACHE_WIDTH-1:0] wr_data,
  input  logic                   wr_ready,
  output logic                   busy,
  output logic                   done
);

  localparam int NUM_LANES = CACHE_WIDTH / DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  typedef logic [NUM_LANES-1:0][DATA_WIDTH-1:0] line_t;

  state_t               state;
  state_t               state_nxt;
  logic [CNT_WIDTH-1:0] batch_len_q;
  logic [CNT_WIDTH-1:0] num_batches_q;
  logic [CNT_WIDTH-1:0] line_cnt;
  logic [CNT_WIDTH-1:0] batch_cnt;
  logic [CNT_WIDTH-1:0] in_line;
  logic [CNT_WIDTH-1:0] in_batch;
  logic                 in_all;
  line_t                acc_lanes;
  line_t                wr_lanes;
  logic [CACHE_WIDTH-1:0] fifo_dout;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push;
  logic                 pop;
  logic                 last_line;
  logic                 last_batch;
  logic                 job_ok;
  logic                 start_ok;

  assign busy       = (state == RUN) || (state == WAIT_RES) || (state == WRITE);
  assign done       = (state == FIN);
  assign rd_ready   = busy & ~fifo_full & ~in_all;
  assign push       = rd_valid & rd_ready;
  assign last_line  = (line_cnt == batch_len_q - ONE);
  assign last_batch = (batch_cnt == num_batches_q - ONE);
  assign job_ok     = (batch_len != '0) && (num_batches != '0);
  assign start_ok   = (state == IDLE) && start;
  assign acc_array  = acc_lanes;
  assign wr_data    = wr_lanes;

  line_fifo #(
    .WIDTH (CACHE_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (rd_data),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = job_ok ? RUN : FIN;
        end
      end
      RUN: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (last_line) begin
            state_nxt = WAIT_RES;
          end
        end
      end
      WAIT_RES: begin
        if (acc_ready) begin
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        if (wr_ready) begin
          state_nxt = last_batch ? FIN : RUN;
        end
      end
      FIN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Input-side admission: counts accepted lines as (line, batch) so the job
  // total is reached without multiplying batch_len by num_batches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_line  <= '0;
      in_batch <= '0;
      in_all   <= 1'b0;
    end else if (start_ok) begin
      in_line  <= '0;
      in_batch <= '0;
      in_all   <= 1'b0;
    end else if (push) begin
      if (in_line == batch_len_q - ONE) begin
        in_line <= '0;
        if (in_batch == num_batches_q - ONE) begin
          in_all <= 1'b1;
        end else begin
          in_batch <= in_batch + ONE;
        end
      end else begin
        in_line <= in_line + ONE;
      end
    end
  end

  // Strobes default low each cycle so every pop yields exactly one single-cycle pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      batch_len_q   <= '0;
      num_batches_q <= '0;
      line_cnt      <= '0;
      batch_cnt     <= '0;
      acc_inc       <= 1'b0;
      acc_out       <= 1'b0;
      acc_lanes     <= '0;
      wr_valid      <= 1'b0;
      wr_lanes      <= '0;
    end else begin
      acc_inc <= 1'b0;
      acc_out <= 1'b0;
      if (start_ok) begin
        batch_len_q   <= batch_len;
        num_batches_q <= num_batches;
        line_cnt      <= '0;
        batch_cnt     <= '0;
      end
      if (pop) begin
        acc_lanes <= fifo_dout;
        acc_inc   <= ~last_line;
        acc_out   <= last_line;
        if (!last_line) begin
          line_cnt <= line_cnt + ONE;
        end
      end
      if ((state == WAIT_RES) && acc_ready) begin
        wr_lanes <= acc_res;
        wr_valid <= 1'b1;
      end
      if ((state == WRITE) && wr_ready) begin
        wr_valid <= 1'b0;
        if (!last_batch) begin
          batch_cnt <= batch_cnt + ONE;
          line_cnt  <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_array_accu_feed.sv
// Bench for array_accu_feed with a behavioural accumulator behind it; expected
// results come from lane sums of the lines the bench feeds in.
module tb_array_accu_feed;

  localparam int CW   = 512;
  localparam int DW   = 32;
  localparam int NL   = CW / DW;
  localparam int CNTW = 16;

  typedef logic [CW-1:0] line_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [CNTW-1:0] batch_len;
  logic [CNTW-1:0] num_batches;
  logic            rd_valid;
  line_t           rd_data;
  logic            rd_ready;
  logic            acc_inc;
  logic            acc_out;
  line_t           acc_array;
  logic            acc_ready;
  line_t           acc_res;
  logic            wr_valid;
  line_t           wr_data;
  logic            wr_ready;
  logic            busy;
  logic            done;

  int checks = 0;
  int errors = 0;

  line_t src_q[$];
  line_t exp_res[$];
  line_t res_q[$];
  bit    strb_q[$];
  line_t strb_data_q[$];
  int    strb_cyc_q[$];
  int    cyc_cnt = 0;
  int    done_cnt, done_cyc, hs_cyc, rdy_cnt, busy_cnt, first_block, accepted;
  bit    both_seen, stall_bad, prev_stall;
  line_t prev_wd;
  line_t acc_sum;

  always #5 clk = ~clk;

  array_accu_feed dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .batch_len   (batch_len),
    .num_batches (num_batches),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .rd_ready    (rd_ready),
    .acc_inc     (acc_inc),
    .acc_out     (acc_out),
    .acc_array   (acc_array),
    .acc_ready   (acc_ready),
    .acc_res     (acc_res),
    .wr_valid    (wr_valid),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .busy        (busy),
    .done        (done)
  );

  function automatic line_t ladd(input line_t a, input line_t b);
    line_t r;
    for (int l = 0; l < NL; l++) r[l*DW +: DW] = a[l*DW +: DW] + b[l*DW +: DW];
    return r;
  endfunction

  function automatic line_t fill(input logic [DW-1:0] v);
    line_t r;
    for (int l = 0; l < NL; l++) r[l*DW +: DW] = v;
    return r;
  endfunction

  function automatic line_t rand_line();
    line_t r;
    for (int l = 0; l < NL; l++) r[l*DW +: DW] = $urandom;
    return r;
  endfunction

  // Accumulator stand-in: lane sums on inc, result one cycle after out.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_sum   <= '0;
      acc_ready <= 1'b0;
      acc_res   <= '0;
    end else begin
      acc_ready <= 1'b0;
      if (acc_inc) acc_sum <= ladd(acc_sum, acc_array);
      if (acc_out) begin
        acc_res   <= ladd(acc_sum, acc_array);
        acc_ready <= 1'b1;
        acc_sum   <= '0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      cyc_cnt++;
      if (acc_inc && acc_out) both_seen = 1'b1;
      if (acc_inc || acc_out) begin
        strb_q.push_back(acc_out);
        strb_data_q.push_back(acc_array);
        strb_cyc_q.push_back(cyc_cnt);
      end
      if (wr_valid && wr_ready) begin
        res_q.push_back(wr_data);
        hs_cyc = cyc_cnt;
      end
      if (prev_stall && (!wr_valid || wr_data !== prev_wd)) stall_bad = 1'b1;
      prev_stall = wr_valid && !wr_ready;
      prev_wd    = wr_data;
      if (done) begin
        done_cnt++;
        done_cyc = cyc_cnt;
      end
      if (rd_ready) rdy_cnt++;
      if (busy) busy_cnt++;
    end
  end

  task automatic clear_mon();
    res_q.delete();
    strb_q.delete();
    strb_data_q.delete();
    strb_cyc_q.delete();
    done_cnt    = 0;
    done_cyc    = -1;
    hs_cyc      = -100;
    rdy_cnt     = 0;
    busy_cnt    = 0;
    both_seen   = 1'b0;
    stall_bad   = 1'b0;
    prev_stall  = 1'b0;
    first_block = -1;
    accepted    = 0;
  endtask

  task automatic gen_lines(input int n);
    src_q.delete();
    for (int i = 0; i < n; i++) src_q.push_back(rand_line());
  endtask

  // Runs one job over src_q and checks everything common to all jobs.
  task automatic run_job(input int blen, input int nb, input int stall, input bit rnd,
                         input bit mid_start, input string tag);
    int    total = blen * nb;
    int    cyc = 0;
    int    stall_left = stall;
    int    bad_idx = -1;
    line_t s;
    bit    exp_strb[$];
    exp_res.delete();
    for (int b = 0; b < nb; b++) begin
      s = '0;
      for (int l = 0; l < blen; l++) begin
        s = ladd(s, src_q[b*blen + l]);
        exp_strb.push_back(l == blen - 1);
      end
      exp_res.push_back(s);
    end
    clear_mon();
    batch_len = CNTW'(blen);
    num_batches = CNTW'(nb);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (done_cnt == 0 && cyc < 4000) begin
      rd_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      rd_data  = (accepted < src_q.size()) ? src_q[accepted] : rand_line();
      if (wr_valid && stall_left > 0) begin
        wr_ready = 1'b0;
        stall_left--;
      end else begin
        wr_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (mid_start && cyc == 5) begin
        start = 1'b1;
        batch_len = 1;
        num_batches = 1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (busy && !rd_ready && accepted < total && first_block < 0) first_block = accepted;
      if (rd_valid && rd_ready) accepted++;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    wr_ready = 1'b0;
    rd_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (rd_valid && rd_ready) accepted++;
      @(posedge clk); #1;
    end
    rd_valid = 1'b0;

    checks++;
    if (done_cnt !== 1) begin
      errors++;
      $display("[TB] FAIL %s done_count got %0d want 1", tag, done_cnt);
    end
    checks++;
    if (accepted !== total) begin
      errors++;
      $display("[TB] FAIL %s lines_accepted got %0d want %0d", tag, accepted, total);
    end
    checks++;
    if (res_q.size() !== nb) begin
      errors++;
      $display("[TB] FAIL %s result_count got %0d want %0d", tag, res_q.size(), nb);
    end
    for (int i = 0; i < nb && i < res_q.size(); i++) begin
      checks++;
      if (res_q[i] !== exp_res[i]) begin
        errors++;
        $display("[TB] FAIL %s wr_data[%0d] got %h want %h", tag, i, res_q[i][63:0], exp_res[i][63:0]);
      end
    end
    checks++;
    if (strb_q != exp_strb) begin
      errors++;
      $display("[TB] FAIL %s strobe_seq got %0d strobes want %0d (sequence differs)", tag,
               strb_q.size(), exp_strb.size());
    end
    for (int i = 0; i < strb_data_q.size() && i < src_q.size(); i++)
      if (bad_idx < 0 && strb_data_q[i] !== src_q[i]) bad_idx = i;
    checks++;
    if (bad_idx >= 0 || strb_data_q.size() != total) begin
      errors++;
      $display("[TB] FAIL %s acc_array_passthrough got bad index %0d count %0d want none count %0d",
               tag, bad_idx, strb_data_q.size(), total);
    end
    checks++;
    if (both_seen !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s inc_and_out_together got %0b want 0", tag, both_seen);
    end
    checks++;
    if (done_cyc !== hs_cyc + 1) begin
      errors++;
      $display("[TB] FAIL %s done_after_handshake got cycle %0d want %0d", tag, done_cyc, hs_cyc + 1);
    end
    checks++;
    if (stall_bad !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s wr_hold_while_stalled got %0b want 0", tag, stall_bad);
    end
  endtask

  task automatic check_quiet_outputs(input string tag);
    checks++;
    if ({acc_inc, acc_out, wr_valid, busy, done, rd_ready} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL %s ctrl_outputs got %b want 000000", tag,
               {acc_inc, acc_out, wr_valid, busy, done, rd_ready});
    end
    checks++;
    if (acc_array !== '0 || wr_data !== '0) begin
      errors++;
      $display("[TB] FAIL %s data_outputs got acc %h wr %h want 0", tag, acc_array[63:0], wr_data[63:0]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    batch_len = '0;
    num_batches = '0;
    rd_valid = 1'b0;
    rd_data = '0;
    wr_ready = 1'b0;
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    check_quiet_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_batch();
    src_q = '{fill(32'd1), fill(32'd2), fill(32'd3), fill(32'd4)};
    run_job(4, 1, 0, 1'b0, 1'b0, "basic");
    checks++;
    if (res_q.size() != 1 || res_q[0] !== fill(32'd10)) begin
      errors++;
      $display("[TB] FAIL basic lanes_sum got %h want %h", res_q.size() ? res_q[0][63:0] : 64'hx,
               fill(32'd10) >> (CW - 64));
    end
    checks++;
    if (strb_cyc_q.size() != 4 || strb_cyc_q[3] - strb_cyc_q[0] != 3) begin
      errors++;
      $display("[TB] FAIL basic strobe_spacing got %0d strobes span %0d want 4 span 3", strb_cyc_q.size(),
               strb_cyc_q.size() == 4 ? strb_cyc_q[3] - strb_cyc_q[0] : -1);
    end
  endtask

  task automatic test_single_line_batches();
    int incs = 0;
    src_q = '{fill(32'd5), fill(32'd6), fill(32'd7)};
    run_job(1, 3, 0, 1'b0, 1'b0, "single");
    foreach (strb_q[i]) if (!strb_q[i]) incs++;
    checks++;
    if (incs != 0) begin
      errors++;
      $display("[TB] FAIL single inc_count got %0d want 0", incs);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= res_q.size() || res_q[i] !== fill(32'(5 + i))) begin
        errors++;
        $display("[TB] FAIL single result_lane[%0d] got %h want %0d", i,
                 i < res_q.size() ? res_q[i][31:0] : 32'hx, 5 + i);
      end
    end
  endtask

  task automatic test_back_to_back_stall();
    gen_lines(24);
    run_job(12, 2, 20, 1'b0, 1'b0, "stall");
    checks++;
    if (first_block !== 20) begin
      errors++;
      $display("[TB] FAIL stall rd_ready_drop got at %0d lines want at 20", first_block);
    end
  endtask

  task automatic test_wrap();
    src_q = '{fill(32'hFFFF_FFFF), fill(32'h0000_0001)};
    run_job(2, 1, 0, 1'b0, 1'b0, "wrap");
    checks++;
    if (res_q.size() != 1 || res_q[0] !== '0) begin
      errors++;
      $display("[TB] FAIL wrap lanes got %h want 0", res_q.size() ? res_q[0][63:0] : 64'hx);
    end
  endtask

  task automatic test_zero_len(input int blen, input int nb, input string tag);
    int t0;
    clear_mon();
    batch_len = CNTW'(blen);
    num_batches = CNTW'(nb);
    rd_valid = 1'b1;
    rd_data = rand_line();
    start = 1'b1;
    t0 = cyc_cnt + 1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rd_valid = 1'b0;
    checks++;
    if (done_cnt !== 1 || done_cyc - t0 < 1 || done_cyc - t0 > 2) begin
      errors++;
      $display("[TB] FAIL %s done_pulse got count %0d latency %0d want count 1 latency 1..2", tag,
               done_cnt, done_cyc - t0);
    end
    checks++;
    if (rdy_cnt !== 0 || busy_cnt !== 0 || strb_q.size() !== 0) begin
      errors++;
      $display("[TB] FAIL %s no_traffic got rd_ready %0d busy %0d strobes %0d want 0 0 0", tag,
               rdy_cnt, busy_cnt, strb_q.size());
    end
  endtask

  task automatic test_start_while_busy();
    gen_lines(4);
    run_job(2, 2, 0, 1'b0, 1'b1, "busy_start");
  endtask

  task automatic test_reset_mid_job();
    int n = 0;
    int guard = 0;
    gen_lines(4);
    clear_mon();
    batch_len = 4;
    num_batches = 1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rd_valid = 1'b1;
    rd_data = src_q[0];
    while (n < 2 && guard < 20) begin
      @(negedge clk);
      if (rd_valid && rd_ready) n++;
      @(posedge clk); #1;
      rd_data = src_q[n];
      guard++;
    end
    rd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (strb_q.size() !== 2 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midrst pre_reset got strobes %0d busy %0b want 2 1", strb_q.size(), busy);
    end
    rst = 1'b1;
    #1;
    check_quiet_outputs("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (strb_q.size() !== 0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrst post_reset got strobes %0d busy %0b want 0 0", strb_q.size(), busy);
    end
    gen_lines(4);
    run_job(4, 1, 0, 1'b0, 1'b0, "midrst_rerun");
  endtask

  task automatic test_random_jobs();
    int blen, nb;
    for (int j = 0; j < 4; j++) begin
      blen = $urandom_range(1, 5);
      nb   = $urandom_range(1, 3);
      gen_lines(blen * nb);
      run_job(blen, nb, $urandom_range(0, 5), 1'b1, 1'b0, $sformatf("rand%0d", j));
    end
  endtask

  initial begin
    test_reset();
    test_basic_batch();
    test_single_line_batches();
    test_back_to_back_stall();
    test_wrap();
    test_zero_len(0, 3, "zero_len");
    test_zero_len(2, 0, "zero_batches");
    test_start_while_busy();
    test_reset_mid_job();
    test_random_jobs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
